// File: rtl/fifo_serial_drain_if.sv
// fifo_serial_drain_if: FIFO read port as seen by the serial drain
interface fifo_serial_drain_if;
  logic rd_en;
  logic fifo_empty;
  logic [7:0] fifo_data;
  modport master (output rd_en, input fifo_empty, fifo_data);
  modport slave (input rd_en, output fifo_empty, fifo_data);
endinterface

// File: rtl/fifo_serial_drain.sv
// fifo_serial_drain: pops FIFO bytes and shifts them out LSB-first as async frames; define PARITY_EN for an even parity bit
module fifo_serial_drain #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       rd_clk,
  input  logic                       reset_in,
  input  logic                       tx_en,
  fifo_serial_drain_if.master        fifo,
  output logic                       tx_out,
  output logic                       tx_busy,
  output logic [15:0]                frames_sent
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic last, go;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign go = tx_en && !fifo.fifo_empty;
  always_ff @(posedge rd_clk) begin
    if (reset_in) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frames_sent <= '0;
`ifdef PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= (state == LOAD || last) ? '0 : cnt + 1'b1;
      if (state == LOAD) begin
        shift   <= fifo.fifo_data;
        bit_cnt <= '0;
`ifdef PARITY_EN
        par     <= ^fifo.fifo_data;
`endif
      end else if (state == DATA && last) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && last) frames_sent <= frames_sent + 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = go ? POP : IDLE;
      POP:    state_nx = LOAD;
      LOAD:   state_nx = START;
      START:  if (last) state_nx = DATA;
`ifdef PARITY_EN
      DATA:   if (last && bit_cnt == 3'd7) state_nx = PARITY;
      PARITY: if (last) state_nx = STOP;
`else
      DATA:   if (last && bit_cnt == 3'd7) state_nx = STOP;
`endif
      STOP:   if (last) state_nx = go ? POP : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // outputs decode registered state only, so fifo_empty never reaches rd_en combinationally
  assign fifo.rd_en = state == POP;
  assign tx_busy = state != IDLE;
`ifdef PARITY_EN
  assign tx_out = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
`else
  assign tx_out = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
endmodule

// File: tb/tb_fifo_serial_drain.sv
// tb_fifo_serial_drain: FIFO model plus serial-frame scoreboard for fifo_serial_drain
module tb_fifo_serial_drain;
  localparam int C = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic rd_clk = 1'b0;
  logic reset_in, tx_en, tx_out, tx_busy;
  logic [15:0] frames_sent;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] eq[$];
  int pop_cyc[$];
  int cyc = 0, npop = 0, total = 0, bad = 0;
  fifo_serial_drain_if fif();
  assign fif.fifo_empty = fifo_empty;
  assign fif.fifo_data = fifo_data;
  fifo_serial_drain #(.CLKS_PER_BIT(C)) dut (
    .rd_clk(rd_clk), .reset_in(reset_in), .tx_en(tx_en), .fifo(fif.master),
    .tx_out(tx_out), .tx_busy(tx_busy), .frames_sent(frames_sent));
  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc <= cyc + 1;
  always @(posedge rd_clk) begin
    if (fif.rd_en === 1'b1 && fq.size() != 0) fifo_data <= fq.pop_front();
    fifo_empty <= fq.size() == 0;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    eq.push_back(d);
  endtask
  task automatic wait_idle();
    int n = 0;
    repeat (4) @(negedge rd_clk);
    while ((tx_busy || (tx_en && !fifo_empty)) && n < 3000) begin
      @(negedge rd_clk);
      n++;
    end
    check("idle_wait", 16'(n < 3000), 16'd1);
  endtask
  task automatic wait_pop(input int target);
    int n = 0;
    while (npop < target && n < 500) begin
      @(negedge rd_clk);
      n++;
    end
    check("pop_wait", 16'(npop >= target), 16'd1);
  endtask
  // frame monitor: on each pop, expect the start bit two cycles later and every bit held C cycles
  initial forever begin
    @(negedge rd_clk);
    if (fif.rd_en === 1'b1 && !reset_in) begin
      logic [7:0] b8;
      logic [15:0] ef, obs;
      logic st, ab;
      npop++;
      pop_cyc.push_back(cyc);
      check("rd_nonempty", 16'(fifo_empty), 16'd0);
      check("gap_pop", 16'(tx_out), 16'd1);
      check("exp_avail", 16'(eq.size() != 0), 16'd1);
      b8 = eq.size() != 0 ? eq.pop_front() : 8'h00;
      ef = '0;
      ef[8:1] = b8;
`ifdef PARITY_EN
      ef[9] = ^b8;
`endif
      ef[NB-1] = 1'b1;
      obs = '0;
      st = 1'b1;
      ab = 1'b0;
      @(negedge rd_clk);
      if (reset_in) ab = 1'b1;
      else check("gap_load", 16'(tx_out), 16'd1);
      for (int b = 0; b < NB && !ab; b++)
        for (int c = 0; c < C && !ab; c++) begin
          @(negedge rd_clk);
          if (reset_in) ab = 1'b1;
          else if (c == 0) obs[b] = tx_out;
          else if (tx_out !== obs[b]) st = 1'b0;
        end
      if (!ab) begin
        check("frame", obs, ef);
        check("bit_hold", 16'(st), 16'd1);
      end
    end
  end
  initial begin
    int base;
    logic ok;
    reset_in = 1'b1;
    tx_en = 1'b1;
    @(posedge rd_clk);
    #1;
    check("rst_tx_out", 16'(tx_out), 16'd1);
    check("rst_rd_en", 16'(fif.rd_en), 16'd0);
    check("rst_busy", 16'(tx_busy), 16'd0);
    check("rst_frames", frames_sent, 16'd0);
    @(posedge rd_clk);
    #1 reset_in = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge rd_clk);
      ok &= tx_out === 1'b1 && fif.rd_en === 1'b0 && tx_busy === 1'b0 && frames_sent === 16'd0;
    end
    check("idle_hold", 16'(ok), 16'd1);
    base = npop;
    push(8'hA5);
    wait_idle();
    check("single_pops", 16'(npop - base), 16'd1);
    check("frames_1", frames_sent, 16'd1);
    base = npop;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle();
    check("stream_pops", 16'(npop - base), 16'd3);
    check("stream_gap1", 16'(pop_cyc[base+1] - pop_cyc[base]), 16'(NB * C + 2));
    check("stream_gap2", 16'(pop_cyc[base+2] - pop_cyc[base+1]), 16'(NB * C + 2));
    check("frames_4", frames_sent, 16'd4);
    base = npop;
    push(8'h07);
    push(8'h03);
    wait_idle();
    check("par_gap", 16'(pop_cyc[base+1] - pop_cyc[base]), 16'(NB * C + 2));
    check("frames_6", frames_sent, 16'd6);
    base = npop;
    push(8'h55);
    push(8'h66);
    wait_pop(base + 1);
    repeat (2 + 2 * C + 2) @(negedge rd_clk);
    @(posedge rd_clk);
    #1 tx_en = 1'b0;
    wait_idle();
    repeat (20) @(negedge rd_clk);
    check("en_low_pops", 16'(npop - base), 16'd1);
    check("en_low_frames", frames_sent, 16'd7);
    check("en_low_queued", 16'(fifo_empty), 16'd0);
    tx_en = 1'b1;
    wait_idle();
    check("en_high_pops", 16'(npop - base), 16'd2);
    check("frames_8", frames_sent, 16'd8);
    base = npop;
    push(8'h81);
    push(8'h42);
    wait_pop(base + 1);
    repeat (2 + 4 * C + 1) @(negedge rd_clk);
    @(posedge rd_clk);
    #1 reset_in = 1'b1;
    @(posedge rd_clk);
    #1 reset_in = 1'b0;
    check("midrst_tx_out", 16'(tx_out), 16'd1);
    check("midrst_busy", 16'(tx_busy), 16'd0);
    check("midrst_frames", frames_sent, 16'd0);
    wait_idle();
    check("after_rst_pops", 16'(npop - base), 16'd2);
    check("after_rst_frames", frames_sent, 16'd1);
    @(posedge rd_clk);
    #1 force dut.frames_sent = 16'hFFFF;
    @(negedge rd_clk);
    release dut.frames_sent;
    push(8'h5A);
    wait_idle();
    check("frames_wrap", frames_sent, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
